// File: rtl/collision_scanner.sv
// collision_scanner: end-of-game detector for the snake game.
// On each head-move strobe the new head is checked against the playfield frame,
// then against the active tail segments one segment per clock. A collision
// latches game_over (with the segment index in hit_seg), a clean move at full
// length latches victory.
// Optional build macro: WRAP_WALLS_EN -- the frame is a torus, so the wall
// check never reports a hit (position wrapping is done by the movement logic).
module collision_scanner #(
    parameter  int X_W     = 7,
    parameter  int Y_W     = 6,
    parameter  int MAX_LEN = 15,
    parameter  int WIN_LEN = 15,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   move_stb,
    input  logic [X_W-1:0]         head_x,
    input  logic [Y_W-1:0]         head_y,
    input  logic [MAX_LEN*X_W-1:0] tail_x,
    input  logic [MAX_LEN*Y_W-1:0] tail_y,
    input  logic [LEN_W-1:0]       length,
    input  logic [X_W-1:0]         x_min,
    input  logic [X_W-1:0]         x_max,
    input  logic [Y_W-1:0]         y_min,
    input  logic [Y_W-1:0]         y_max,
    output logic                   busy,
    output logic                   check_done,
    output logic                   game_over,
    output logic                   victory,
    output logic [LEN_W-1:0]       hit_seg,
    output logic                   overrun
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] WIN_LEN_L = LEN_W'(WIN_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [X_W-1:0]   head_x_q;
    logic [Y_W-1:0]   head_y_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;

    logic [LEN_W:0]   len_ext;
    logic [LEN_W-1:0] len_clamped;
    logic             wall_hit;
    logic [X_W-1:0]   seg_x;
    logic [Y_W-1:0]   seg_y;
    logic             seg_hit;

    // Lengths beyond the number of segments on the bus saturate at MAX_LEN;
    // the one-bit extension keeps the compare meaningful when LEN_W is exactly full.
    assign len_ext     = {1'b0, length};
    assign len_clamped = (len_ext > (LEN_W+1)'(MAX_LEN)) ? MAX_LEN_L : length;

`ifdef WRAP_WALLS_EN
    logic unused_frame;
    assign unused_frame = ^{x_min, x_max, y_min, y_max};
    assign wall_hit     = 1'b0;
`else
    assign wall_hit = (head_x_q <= x_min) || (head_x_q >= x_max) ||
                      (head_y_q <= y_min) || (head_y_q >= y_max);
`endif

    // Select the tail segment addressed by the scan index and compare with the latched head.
    always_comb begin
        seg_x   = tail_x[idx*X_W +: X_W];
        seg_y   = tail_y[idx*Y_W +: Y_W];
        seg_hit = (seg_x == head_x_q) && (seg_y == head_y_q);
    end

    // Check sequencer: IDLE accepts a move, WALL tests the frame, SCAN walks the
    // segments with early exit on a hit, DONE pulses check_done and decides victory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            head_x_q   <= '0;
            head_y_q   <= '0;
            len_q      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            game_over  <= 1'b0;
            victory    <= 1'b0;
            hit_seg    <= '0;
            overrun    <= 1'b0;
        end else if (restart) begin
            state      <= IDLE;
            head_x_q   <= '0;
            head_y_q   <= '0;
            len_q      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            game_over  <= 1'b0;
            victory    <= 1'b0;
            hit_seg    <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    check_done <= 1'b0;
                    if (move_stb && !game_over && !victory) begin
                        head_x_q <= head_x;
                        head_y_q <= head_y;
                        len_q    <= len_clamped;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= WALL;
                    end
                end
                WALL: begin
                    if (wall_hit) begin
                        game_over  <= 1'b1;
                        hit_seg    <= MAX_LEN_L;
                        check_done <= 1'b1;
                        state      <= DONE;
                    end else if (len_q == '0) begin
                        check_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (seg_hit) begin
                        game_over  <= 1'b1;
                        hit_seg    <= idx;
                        check_done <= 1'b1;
                        state      <= DONE;
                    end else if (idx == len_q - 1'b1) begin
                        check_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    check_done <= 1'b0;
                    busy       <= 1'b0;
                    if (!game_over && (len_q >= WIN_LEN_L)) begin
                        victory <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    check_done <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            if (move_stb && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
